// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl
// -----------------------------------------------------------------------------
// Acquisition controller that feeds the BRAM store stage. Software arms the
// block, it waits for a rising edge on the trigger and then stores one ADC A/B
// sample pair every `decimation` clocks. Each sample is presented as a
// registered data/address/write_enable triple. The address advances by
// ADDR_STEP bytes per sample. After the programmed number of samples the block
// parks in DONE and holds done high until the next arm, an abort or a reset.
//
// Ports
//   clk, rst       : system clock, synchronous active-high reset
//   arm, abort     : single-cycle software command pulses (abort has priority)
//   trigger        : level trigger, rising edge starts a capture when armed
//   num_samples    : sample count, latched on arm (0 or too large -> MAX_SAMPLES)
//   decimation     : store 1 of every N clocks, latched on arm (0 -> 1)
//   adc_a, adc_b   : 14-bit two's complement ADC channels
//   data_out_A/B   : registered sample pair for the BRAM
//   write_address  : byte address of the sample currently presented
//   write_enable   : one-cycle strobe per stored sample
//   busy, done     : status for the PS register bank
//   sample_count   : samples stored so far in this acquisition
// -----------------------------------------------------------------------------
module bram_capture_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned MAX_SAMPLES = 16384,
  parameter int unsigned CNT_W       = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [15:0]      decimation,
  input  logic [13:0]      adc_a,
  input  logic [13:0]      adc_b,
  output logic [13:0]      data_out_A,
  output logic [13:0]      data_out_B,
  output logic [31:0]      write_address,
  output logic             write_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      STEP_32  = 32'(ADDR_STEP);

  state_t           state;
  logic             trig_prev;
  logic [15:0]      dec_cnt;
  logic [15:0]      dec_lat;
  logic [CNT_W-1:0] num_lat;

  logic             trig_edge;
  logic             arm_ok;
  logic             strobe;
  logic             last_write;
  logic [CNT_W-1:0] next_count;
  logic [CNT_W-1:0] num_clamped;
  logic [15:0]      dec_clamped;
  logic [15:0]      dec_next;

  // Next-state helpers. A strobe happens whenever the decimation counter is at
  // zero while capturing; since the counter is cleared on arm, the first strobe
  // lands on the first clock after entering CAPTURE. The last write is the one
  // whose post-increment count reaches the latched sample total.
  always_comb begin
    trig_edge   = trigger & ~trig_prev;
    arm_ok      = arm & ((state == IDLE) | (state == DONE));
    strobe      = (state == CAPTURE) && (dec_cnt == 16'd0);
    next_count  = sample_count + CNT_ONE;
    last_write  = strobe && (next_count == num_lat);
    num_clamped = ((num_samples == '0) || (num_samples > MAX_CNT)) ? MAX_CNT : num_samples;
    dec_clamped = (decimation == 16'd0) ? 16'd1 : decimation;
    dec_next    = (dec_cnt == dec_lat - 16'd1) ? 16'd0 : dec_cnt + 16'd1;
  end

  // Single control process: state, status and the registered BRAM write
  // stream. write_enable defaults low every clock so it can only ever be a
  // one-cycle pulse. Abort outranks arm; arm is only honoured from IDLE or
  // DONE. busy/done are updated from the DONE state itself, so they change
  // one clock after the final write, together with write_enable falling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      trig_prev     <= 1'b0;
      dec_cnt       <= 16'd0;
      dec_lat       <= 16'd1;
      num_lat       <= MAX_CNT;
      data_out_A    <= '0;
      data_out_B    <= '0;
      write_address <= ADDR_BASE;
      write_enable  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sample_count  <= '0;
    end else begin
      trig_prev    <= trigger;
      write_enable <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (arm_ok) begin
        state         <= ARMED;
        num_lat       <= num_clamped;
        dec_lat       <= dec_clamped;
        sample_count  <= '0;
        dec_cnt       <= 16'd0;
        done          <= 1'b0;
        busy          <= 1'b1;
        write_address <= ADDR_BASE;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          ARMED: begin
            if (trig_edge) begin
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            dec_cnt <= dec_next;
            if (strobe) begin
              data_out_A    <= adc_a;
              data_out_B    <= adc_b;
              write_enable  <= 1'b1;
              write_address <= ADDR_BASE + STEP_32 * 32'(sample_count);
              sample_count  <= next_count;
              if (last_write) begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb_bram_capture_ctrl
// -----------------------------------------------------------------------------
// Bench for bram_capture_ctrl. A behavioural model computes the expected
// outputs from the capture rules (strobe k happens at edge start+1+k*dec, lands
// at 4*k), and one compare process checks every DUT output against it on each
// falling edge. Directed scenarios add hand-computed literal expectations,
// followed by a randomized command/trigger/ADC phase.
// -----------------------------------------------------------------------------
module tb_bram_capture_ctrl;

  localparam int MAXS = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        trigger;
  logic [14:0] num_samples;
  logic [15:0] decimation;
  logic [13:0] adc_a;
  logic [13:0] adc_b;
  logic [13:0] data_out_A;
  logic [13:0] data_out_B;
  logic [31:0] write_address;
  logic        write_enable;
  logic        busy;
  logic        done;
  logic [14:0] sample_count;

  int checks = 0;
  int errors = 0;
  logic ramp_mode = 1'b1;

  // Writes observed from the DUT, with the model edge index they happened on.
  logic [31:0] wr_addr[$];
  logic [13:0] wr_a[$];
  int          wr_cyc[$];

  int          trig_cyc;
  logic [13:0] diff;

  bram_capture_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .abort         (abort),
    .trigger       (trigger),
    .num_samples   (num_samples),
    .decimation    (decimation),
    .adc_a         (adc_a),
    .adc_b         (adc_b),
    .data_out_A    (data_out_A),
    .data_out_B    (data_out_B),
    .write_address (write_address),
    .write_enable  (write_enable),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one clock worth of inputs, then wait for the following falling edge.
  task automatic applyStimulus(input logic p_arm, input logic p_abort, input logic p_trig);
    arm     = p_arm;
    abort   = p_abort;
    trigger = p_trig;
    if (ramp_mode) begin
      adc_a = adc_a + 14'd1;
      adc_b = adc_b - 14'd1;
    end else begin
      adc_a = 14'($urandom);
      adc_b = 14'($urandom);
    end
    @(negedge clk);
  endtask

  // Idle with the trigger held until done, bounded by a cycle budget.
  task automatic waitDone(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      applyStimulus(1'b0, 1'b0, trigger);
      n++;
    end
    checkOutput("wait_done", 32'(done), 32'd1);
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_a.delete();
    wr_cyc.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Mode is the acquisition phase; during capture the
  // strobe schedule is derived arithmetically from the edge the capture began.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;
  int          m_mode  = M_IDLE;
  int          m_start = 0;
  int          m_n     = MAXS;
  int          m_d     = 1;
  int          cyc     = 0;
  logic        m_prev  = 1'b0;
  logic [13:0] e_a     = '0;
  logic [13:0] e_b     = '0;
  logic [31:0] e_addr  = '0;
  logic        e_we    = 1'b0;
  logic        e_busy  = 1'b0;
  logic        e_done  = 1'b0;
  int          e_cnt   = 0;

  always @(posedge clk) begin
    int   off;
    int   k;
    logic rise;
    cyc++;
    if (rst) begin
      m_mode = M_IDLE; m_prev = 1'b0;
      e_a = '0; e_b = '0; e_addr = '0; e_we = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_cnt = 0;
    end else begin
      rise   = trigger && !m_prev;
      m_prev = trigger;
      e_we   = 1'b0;
      if (abort) begin
        m_mode = M_IDLE; e_busy = 1'b0; e_done = 1'b0;
      end else if (arm && (m_mode == M_IDLE || m_mode == M_DONE)) begin
        m_n    = (num_samples == 0 || int'(num_samples) > MAXS) ? MAXS : int'(num_samples);
        m_d    = (decimation == 0) ? 1 : int'(decimation);
        m_mode = M_ARMED;
        e_cnt  = 0; e_done = 1'b0; e_busy = 1'b1; e_addr = '0;
      end else if (m_mode == M_ARMED) begin
        if (rise) begin
          m_mode  = M_CAPT;
          m_start = cyc;
        end
      end else if (m_mode == M_CAPT) begin
        off = cyc - m_start - 1;
        if (off % m_d == 0) begin
          k      = off / m_d;
          e_we   = 1'b1;
          e_a    = adc_a;
          e_b    = adc_b;
          e_addr = 32'(4 * k);
          e_cnt  = k + 1;
          if (k + 1 == m_n) m_mode = M_DONE;
        end
      end else if (m_mode == M_DONE) begin
        e_busy = 1'b0;
        e_done = 1'b1;
      end
    end
  end

  // Compare every output against the model on each falling edge and log writes.
  always @(negedge clk) begin
    checkOutput("data_out_A", 32'(data_out_A), 32'(e_a));
    checkOutput("data_out_B", 32'(data_out_B), 32'(e_b));
    checkOutput("write_address", write_address, e_addr);
    checkOutput("write_enable", 32'(write_enable), 32'(e_we));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("done", 32'(done), 32'(e_done));
    checkOutput("sample_count", 32'(sample_count), 32'(e_cnt));
    if (write_enable === 1'b1) begin
      wr_addr.push_back(write_address);
      wr_a.push_back(data_out_A);
      wr_cyc.push_back(cyc);
    end
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    num_samples = '0; decimation = '0; adc_a = '0; adc_b = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_address", write_address, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(sample_count), 32'd0);
    rst = 1'b0;

    // Four back-to-back samples.
    $display("[TB] scenario 1: 4 samples, decimation 1");
    clearLog();
    num_samples = 15'd4; decimation = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    trig_cyc = cyc;
    waitDone(40);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s1_writes", 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      checkOutput("s1_addr", wr_addr[i], 32'(4 * i));
      checkOutput("s1_cycle", 32'(wr_cyc[i]), 32'(trig_cyc + 1 + i));
      diff = wr_a[i] - wr_a[0];
      checkOutput("s1_data_step", 32'(diff), 32'(i));
    end
    checkOutput("s1_done", 32'(done), 32'd1);
    checkOutput("s1_count", 32'(sample_count), 32'd4);
    checkOutput("s1_busy", 32'(busy), 32'd0);

    // Decimation 3 on a ramp.
    $display("[TB] scenario 2: 3 samples, decimation 3");
    clearLog();
    num_samples = 15'd3; decimation = 16'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone(40);
    checkOutput("s2_writes", 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      checkOutput("s2_addr", wr_addr[i], 32'(4 * i));
    end
    for (int i = 1; i < 3 && i < wr_addr.size(); i++) begin
      diff = wr_a[i] - wr_a[i-1];
      checkOutput("s2_data_step", 32'(diff), 32'd3);
      checkOutput("s2_strobe_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd3);
    end

    // Zero count and zero decimation clamp to a full-depth capture.
    $display("[TB] scenario 3: full depth capture");
    clearLog();
    num_samples = 15'd0; decimation = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone(17000);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s3_writes", 32'(wr_addr.size()), 32'd16384);
    if (wr_addr.size() > 0) checkOutput("s3_last_addr", wr_addr[wr_addr.size()-1], 32'h0000_FFFC);
    checkOutput("s3_count", 32'(sample_count), 32'd16384);
    checkOutput("s3_done", 32'(done), 32'd1);

    // Trigger already high at arm; re-arm during capture is ignored.
    $display("[TB] scenario 4: trigger high at arm, re-arm ignored");
    clearLog();
    num_samples = 15'd6; decimation = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s4_no_writes", 32'(wr_addr.size()), 32'd0);
    checkOutput("s4_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitDone(60);
    checkOutput("s4_writes", 32'(wr_addr.size()), 32'd6);
    checkOutput("s4_count", 32'(sample_count), 32'd6);

    // Abort after five of ten writes.
    $display("[TB] scenario 5: abort mid-capture, arm+abort in DONE");
    clearLog();
    num_samples = 15'd10; decimation = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && sample_count != 15'd5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s5_we", 32'(write_enable), 32'd0);
    checkOutput("s5_busy", 32'(busy), 32'd0);
    checkOutput("s5_done", 32'(done), 32'd0);
    checkOutput("s5_count", 32'(sample_count), 32'd5);
    checkOutput("s5_writes", 32'(wr_addr.size()), 32'd5);
    clearLog();
    num_samples = 15'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone(20);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s5b_busy", 32'(busy), 32'd0);
    checkOutput("s5b_done", 32'(done), 32'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s5b_writes", 32'(wr_addr.size()), 32'd2);

    // Reset during capture, then a fresh capture from address zero.
    $display("[TB] scenario 6: reset mid-capture");
    num_samples = 15'd20;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && sample_count != 15'd5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s6_addr", write_address, 32'h0);
    checkOutput("s6_count", 32'(sample_count), 32'd0);
    checkOutput("s6_data", 32'(data_out_A), 32'd0);
    checkOutput("s6_we", 32'(write_enable), 32'd0);
    rst = 1'b0;
    clearLog();
    num_samples = 15'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone(30);
    checkOutput("s6_writes", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() > 0) checkOutput("s6_first_addr", wr_addr[0], 32'h0);

    // Randomized commands, trigger and ADC data against the model.
    $display("[TB] random phase");
    ramp_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic t;
      t = trigger;
      if ($urandom_range(0, 5) == 0) t = ~t;
      rst         = ($urandom_range(0, 299) == 0);
      num_samples = 15'($urandom_range(1, 40));
      decimation  = 16'($urandom_range(0, 4));
      applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 79) == 0, t);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
